// File: rtl/stream_arbiter_pkg.sv
// Shared types and constants for the stream arbiter slice.
package ethhelper_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Source codes for the snoop submodules sharing the stream.
  typedef enum logic [2:0] {
    STREAM_AR = 3'd0,
    STREAM_AW = 3'd1,
    STREAM_R  = 3'd2,
    STREAM_W  = 3'd3,
    STREAM_B  = 3'd4
  } stream_type_t;

  localparam int unsigned N_SRC_DEFAULT = 5;
  localparam int unsigned SRC_IDX_W     = $clog2(N_SRC_DEFAULT);

endpackage

// File: rtl/stream_arbiter_if.sv
// Source-side and stream-side handshake bundle for stream_arbiter.
// master: arbiter view; slave: source/sink environment view.
interface stream_arbiter_if #(
  parameter int unsigned N_SRC      = 5,
  parameter int unsigned DATA_WIDTH = 128
);

  logic [N_SRC-1:0]            src_valid;
  logic [N_SRC-1:0]            src_last;
  logic [N_SRC*DATA_WIDTH-1:0] src_data;
  logic [N_SRC-1:0]            src_ready;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tlast;
  logic                        m_axis_tready;

  modport master (
    input  src_valid, src_last, src_data, m_axis_tready,
    output src_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output src_valid, src_last, src_data, m_axis_tready,
    input  src_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/stream_arbiter_rr_picker.sv
// Wrap-around priority search: first asserted request at or above rr_ptr,
// then wrapping to the lowest index below rr_ptr.
module rr_picker
  import ethhelper_stream_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Two ordered passes implement the rotation without a modulo index.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= rr_ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) < rr_ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Burst-locking round-robin arbiter merging N_SRC beat sources into one
// stream with zero-latency forwarding.
// Optional macro STREAM_ARB_TIMEOUT_EN: force-release a locked burst after
// TIMEOUT_CYCLES consecutive cycles without an accepted beat.
module stream_arbiter
  import ethhelper_stream_pkg::*;
#(
  parameter int unsigned N_SRC          = 5,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  stream_arbiter_if.master bus,
  output logic             timeout_err
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       owner;
  logic [N_SRC-1:0]       pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [N_SRC-1:0]       grant;
  logic [IDX_W-1:0]       g_idx;
  logic [DATA_WIDTH-1:0]  tdata_int;
  logic                   tvalid_int;
  logic                   tlast_int;
  logic                   accept;
  logic                   timeout_hit;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_SRC - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_picker #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (bus.src_valid),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Grant selection: owner while locked, round-robin pick while idle, none in reset.
  always_comb begin
    grant = '0;
    g_idx = '0;
    if (!reset) begin
      if (state == LOCKED) begin
        grant = N_SRC'(1) << owner;
        g_idx = owner;
      end else if (pick_found) begin
        grant = pick_grant;
        g_idx = pick_idx;
      end
    end
  end

  // One-hot mux of the granted source onto the stream; all zero with no grant.
  always_comb begin
    tdata_int = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant[i]) tdata_int = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    tvalid_int = |(grant & bus.src_valid);
    tlast_int  = |(grant & bus.src_last);
  end

  assign accept            = tvalid_int && bus.m_axis_tready;
  assign bus.m_axis_tdata  = tdata_int;
  assign bus.m_axis_tvalid = tvalid_int;
  assign bus.m_axis_tlast  = tlast_int;
  assign bus.src_ready     = grant & {N_SRC{bus.m_axis_tready}};

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt;

  assign timeout_hit = !reset && (state == LOCKED) && !accept &&
                       (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Consecutive locked cycles without an accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == LOCKED) && !accept && !timeout_hit) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign timeout_err = timeout_hit;

  // Arbitration FSM: lock on a non-last accepted beat, release on last (or timeout).
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (tlast_int) begin
              rr_ptr <= next_idx(g_idx);
            end else begin
              state <= LOCKED;
              owner <= g_idx;
            end
          end
        end
        LOCKED: begin
          if ((accept && tlast_int) || timeout_hit) begin
            state  <= IDLE;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 5, meaning number of snoop submodules (AR, AW, R, W, B) sharing the stream.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning width of each source beat and of the stream data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning stall limit for a locked burst; used only when the timeout macro is defined.
REQ-004 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port src_valid, input, N_SRC, per-source beat valid.
REQ-007 SHALL have port src_last, input, N_SRC, per-source last beat of burst.
REQ-008 SHALL have port src_data, input, N_SRC*DATA_WIDTH, per-source beat; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port src_ready, output, N_SRC, per-source grant-and-accept.
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH, stream data.
REQ-011 SHALL have port m_axis_tvalid, output, 1, stream valid.
REQ-012 SHALL have port m_axis_tlast, output, 1, stream last.
REQ-013 SHALL have port m_axis_tready, input, 1, stream ready.
REQ-014 SHALL have port timeout_err, output, 1, one-cycle pulse on forced burst release.

Function
REQ-015 SHALL implement states IDLE and LOCKED, plus a round-robin pointer rr_ptr and a registered owner index.
REQ-016 In IDLE, SHALL grant combinationally the first asserted src_valid found searching from rr_ptr upward, wrapping from N_SRC-1 to 0.
REQ-017 In LOCKED, SHALL grant only the owner, regardless of other src_valid.
REQ-018 SHALL forward the granted source with zero latency: tdata=src_data[g], tvalid=src_valid[g], tlast=src_last[g].
REQ-019 SHALL drive tvalid=0, tlast=0 and tdata=0 when no source is granted.
REQ-020 SHALL drive src_ready[i]=grant[i] AND m_axis_tready; all other src_ready bits are 0.
REQ-021 SHALL define an accepted beat as tvalid AND tready.
REQ-022 In IDLE, an accepted beat with tlast=1 SHALL leave the state IDLE and set rr_ptr to g+1 mod N_SRC.
REQ-023 In IDLE, an accepted beat with tlast=0 SHALL move to LOCKED and set owner to g.
REQ-024 In LOCKED, an accepted beat with tlast=1 SHALL return to IDLE and set rr_ptr to owner+1 mod N_SRC.
REQ-025 When tready=0, SHALL hold grant, state and rr_ptr unchanged.
REQ-026 A source dropping valid mid-burst SHALL NOT release the lock.

Reset
REQ-027 While reset=1, SHALL hold src_ready=0, tvalid=0, tlast=0, tdata=0 and timeout_err=0, set state to IDLE, and clear rr_ptr, owner and the timeout counter to 0.
REQ-028 Reset asserted mid-burst SHALL abandon the lock without emitting tlast; the first cycle after reset is a fresh IDLE arbitration.

Configuration
REQ-029 With STREAM_ARB_TIMEOUT_EN defined, SHALL count consecutive LOCKED cycles without an accepted beat.
REQ-030 With STREAM_ARB_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the block SHALL return to IDLE, set rr_ptr to owner+1, and pulse timeout_err for one cycle; any accepted beat SHALL clear the counter.
REQ-031 Without STREAM_ARB_TIMEOUT_EN, SHALL tie timeout_err to 0, instantiate no counter, and hold the lock indefinitely.

Structure
REQ-032 Package ethhelper_stream_pkg SHALL hold the arb_state_t enum (IDLE, LOCKED), the STREAM_TYPE source codes and the SRC_IDX_W constant ($clog2(N_SRC)).
REQ-033 Sub-module rr_picker SHALL implement the wrap-around priority search: inputs req vector and rr_ptr; outputs one-hot grant and index.

Verification
REQ-034 Single-beat round robin: src_valid=5'b00011 held, all last=1, tready=1 -> stream alternates src0, src1, src0 each cycle.
REQ-035 Burst lock: src2 drives 4 beats with last on beat 4 while src0 is valid throughout -> 4 consecutive src2 beats, then src0 is granted on the next cycle.
REQ-036 Backpressure: tready=0 for 3 cycles mid-burst of src1 -> tdata is stable, src_ready=0, and no other source is granted.
REQ-037 Reset mid-burst: reset=1 after beat 2 of 4 from src3 -> outputs are 0 during reset, and IDLE with rr_ptr=0 follows.
REQ-038 Timeout, with the macro defined and TIMEOUT_CYCLES=8: src4 locks then drops valid -> timeout_err pulses on the 8th idle cycle and src0 is then granted.
